// File: rtl/scan_stream.sv
// scan_stream: walks a memory region (base, length, stride), issues one read
// per word, absorbs RD_LAT cycles of read latency and streams each word out
// over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start                    begins a scan (sampled only while idle)
//   base_addr/length/stride  scan parameters, latched on accepted start
//   read_select, read_en     memory read address and one-cycle strobe
//   read_data                memory word, valid RD_LAT cycles after read_en
//   data_out/data_valid/
//   data_ready/data_last     output stream handshake
//   scan_start               busy, from accepted start until the done cycle
//   done                     one-cycle end-of-scan pulse
//
// Optional build macro SCAN_CHECKSUM_EN: appends one extra beat carrying the
// mod-2^DATA_W sum of all streamed words; that beat carries data_last.
module scan_stream #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] read_select,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              data_last,
    output logic              scan_start,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef SCAN_CHECKSUM_EN
    localparam logic [2:0] S_SUM   = 3'd5;
`endif

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] stride_q;
    logic [LEN_W-1:0]  remaining;
    logic [CNT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] next_addr;
    logic              capture;

    // Status strobes decode straight from the state so reset clears them at once.
    assign read_en    = (state == S_ISSUE);
    assign scan_start = (state != S_IDLE);
    assign done       = (state == S_DONE);

    // Wraps silently modulo 2^ADDR_W.
    assign next_addr = addr + stride_q;
    // Last cycle of the latency window: read_data is valid now.
    assign capture   = (state == S_WAIT) && (lat_cnt == CNT_W'(RD_LAT - 1));

`ifdef SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (state == S_IDLE && start) begin
            sum <= '0;
        end else if (capture) begin
            sum <= sum + read_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            stride_q    <= '0;
            remaining   <= '0;
            lat_cnt     <= '0;
            read_select <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            data_last   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        stride_q  <= stride;
                        remaining <= length;
                        if (length != '0) begin
                            state       <= S_ISSUE;
                            read_select <= base_addr;
                        end else begin
`ifdef SCAN_CHECKSUM_EN
                            // Empty scan still emits the (zero) checksum beat.
                            state      <= S_SUM;
                            data_out   <= '0;
                            data_valid <= 1'b1;
                            data_last  <= 1'b1;
`else
                            state <= S_DONE;
`endif
                        end
                    end
                end
                S_ISSUE: begin
                    state   <= S_WAIT;
                    lat_cnt <= '0;
                end
                S_WAIT: begin
                    if (capture) begin
                        state      <= S_OUT;
                        data_out   <= read_data;
                        data_valid <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
                        data_last  <= 1'b0;
`else
                        data_last  <= (remaining == LEN_W'(1));
`endif
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    // data_valid is always set in this state; outputs hold until accepted.
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        data_last  <= 1'b0;
                        addr       <= next_addr;
                        remaining  <= remaining - LEN_W'(1);
                        if (remaining > LEN_W'(1)) begin
                            state       <= S_ISSUE;
                            read_select <= next_addr;
                        end else begin
`ifdef SCAN_CHECKSUM_EN
                            state      <= S_SUM;
                            data_out   <= sum;
                            data_valid <= 1'b1;
                            data_last  <= 1'b1;
`else
                            state <= S_DONE;
`endif
                        end
                    end
                end
`ifdef SCAN_CHECKSUM_EN
                S_SUM: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        data_last  <= 1'b0;
                        state      <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_stream.sv
// Directed self-checking bench for scan_stream. Two instances share the
// stimulus: dut_a with RD_LAT=1 and dut_b with RD_LAT=3. Each has a memory
// model returning addr[7:0] RD_LAT cycles after read_en (0xEE otherwise).
module tb_scan_stream;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int LW = 15;
`ifdef SCAN_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          data_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [LW-1:0] length = '0;

    logic [AW-1:0] a_sel, b_sel;
    logic          a_ren, b_ren;
    logic [DW-1:0] a_rdata, b_rdata, a_dout, b_dout;
    logic          a_vld, b_vld, a_last, b_last, a_busy, b_busy, a_done, b_done;

    logic [DW-1:0] a_pipe;
    logic [DW-1:0] b_pipe [3];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    int rd_addr_q[$], rd_cyc_q[$], bt_data_q[$], bt_last_q[$], bt_cyc_q[$], dn_q[$];
    int b_rd_cyc_q[$], b_bt_cyc_q[$], b_bt_data_q[$], b_dn_q[$];

    scan_stream #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .stride(stride), .read_select(a_sel), .read_en(a_ren), .read_data(a_rdata),
        .data_out(a_dout), .data_valid(a_vld), .data_ready(data_ready),
        .data_last(a_last), .scan_start(a_busy), .done(a_done)
    );

    scan_stream #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .stride(stride), .read_select(b_sel), .read_en(b_ren), .read_data(b_rdata),
        .data_out(b_dout), .data_valid(b_vld), .data_ready(data_ready),
        .data_last(b_last), .scan_start(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        a_pipe    <= a_ren ? a_sel[7:0] : 8'hEE;
        b_pipe[0] <= b_ren ? b_sel[7:0] : 8'hEE;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_rdata = a_pipe;
    assign b_rdata = b_pipe[2];

    // Event log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (a_ren) begin
                rd_addr_q.push_back(int'(a_sel));
                rd_cyc_q.push_back(cyc);
            end
            if (a_vld && data_ready) begin
                bt_data_q.push_back(int'(a_dout));
                bt_last_q.push_back(int'(a_last));
                bt_cyc_q.push_back(cyc);
            end
            if (a_done) dn_q.push_back(cyc);
            if (b_ren) b_rd_cyc_q.push_back(cyc);
            if (b_vld && data_ready) begin
                b_bt_data_q.push_back(int'(b_dout));
                b_bt_cyc_q.push_back(cyc);
            end
            if (b_done) b_dn_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic clear_q();
        rd_addr_q.delete(); rd_cyc_q.delete(); bt_data_q.delete();
        bt_last_q.delete(); bt_cyc_q.delete(); dn_q.delete();
        b_rd_cyc_q.delete(); b_bt_cyc_q.delete(); b_bt_data_q.delete(); b_dn_q.delete();
    endtask

    task automatic do_start(input int b, input int l, input int s, output int c0);
        base_addr = AW'(b);
        length    = LW'(l);
        stride    = AW'(s);
        start     = 1'b1;
        c0        = cyc;
        step(1);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input bit use_b, input int limit);
        int n = 0;
        while ((use_b ? b_busy : a_busy) && n < limit) begin
            step(1);
            n++;
        end
        chk(use_b ? "b_idle_timeout" : "a_idle_timeout", int'(use_b ? b_busy : a_busy), 0);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_sel"},  int'(a_sel),  0);
        chk({tag, "_ren"},  int'(a_ren),  0);
        chk({tag, "_dout"}, int'(a_dout), 0);
        chk({tag, "_vld"},  int'(a_vld),  0);
        chk({tag, "_last"}, int'(a_last), 0);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_done"}, int'(a_done), 0);
    endtask

    // Compares the logged scan of dut_a against a reference model. With
    // data_ready high, word k is read in cycle c0+1+3k and delivered in c0+3+3k.
    task automatic check_scan(input string tag, input int base, input int len,
                              input int strd, input int c0, input bit timed);
        int a;
        int sum = 0;
        int lastc = c0 + 3 * len;
        chk({tag, "_nrd"}, rd_addr_q.size(), len);
        for (int k = 0; k < len; k++) begin
            a   = (base + k * strd) & 'h3FFF;
            sum = (sum + (a & 'hFF)) & 'hFF;
            chk({tag, "_addr"}, qget(rd_addr_q, k), a);
            chk({tag, "_data"}, qget(bt_data_q, k), a & 'hFF);
            chk({tag, "_last"}, qget(bt_last_q, k), int'((k == len - 1) && !CS));
            if (timed) begin
                chk({tag, "_rdcyc"}, qget(rd_cyc_q, k), c0 + 1 + 3 * k);
                chk({tag, "_btcyc"}, qget(bt_cyc_q, k), c0 + 3 + 3 * k);
            end
        end
`ifdef SCAN_CHECKSUM_EN
        chk({tag, "_nbeat"}, bt_data_q.size(), len + 1);
        chk({tag, "_sum"}, qget(bt_data_q, len), sum);
        chk({tag, "_sumlast"}, qget(bt_last_q, len), 1);
        if (timed) chk({tag, "_sumcyc"}, qget(bt_cyc_q, len), lastc + 1);
        lastc = lastc + 1;
`else
        chk({tag, "_nbeat"}, bt_data_q.size(), len);
`endif
        chk({tag, "_ndone"}, dn_q.size(), 1);
        if (timed) chk({tag, "_donecyc"}, qget(dn_q, 0), lastc + 1);
    endtask

    initial begin
        int c0;

        // Reset state
        step(3);
        chk_zero_a("rst");
        rst = 1'b1;
        step(2);

        // 1: basic scan
        clear_q();
        do_start('h0010, 4, 1, c0);
        wait_idle(1'b0, 200);
        check_scan("t1", 'h0010, 4, 1, c0, 1'b1);
`ifdef SCAN_CHECKSUM_EN
        // 6: checksum beat of the basic scan
        chk("t6_sum", qget(bt_data_q, 4), 'h46);
`endif

        // 2: stride wrap
        clear_q();
        do_start('h3FFE, 3, 3, c0);
        wait_idle(1'b0, 200);
        check_scan("t2", 'h3FFE, 3, 3, c0, 1'b1);

        // 3: backpressure on beat 2 (OUT during cycle c0+6)
        clear_q();
        do_start('h0050, 4, 1, c0);
        step(5);
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_vld", int'(a_vld), 1);
            chk("t3_stall_data", int'(a_dout), 'h51);
            chk("t3_stall_last", int'(a_last), 0);
            chk("t3_stall_nrd", rd_addr_q.size(), 2);
            step(1);
        end
        data_ready = 1'b1;
        wait_idle(1'b0, 200);
        check_scan("t3", 'h0050, 4, 1, c0, 1'b0);

        // 4a: zero length
        clear_q();
        do_start('h0077, 0, 1, c0);
        wait_idle(1'b0, 200);
        check_scan("t4z", 'h0077, 0, 1, c0, 1'b1);

        // 4b: start and new parameters while busy are ignored
        clear_q();
        do_start('h0020, 3, 2, c0);
        step(1);
        base_addr = AW'('h100);
        length    = LW'(7);
        stride    = AW'(5);
        start     = 1'b1;
        step(3);
        start     = 1'b0;
        wait_idle(1'b0, 200);
        check_scan("t4b", 'h0020, 3, 2, c0, 1'b1);

        // 5a: reset during WAIT of word 2 (cycle c0+5), asserted mid-cycle
        wait_idle(1'b1, 200);
        clear_q();
        do_start('h0060, 4, 1, c0);
        step(4);
        #2;
        rst = 1'b0;
        #1;
        chk_zero_a("t5_async");
        step(2);
        rst = 1'b1;
        step(2);
        chk("t5_nodone", dn_q.size(), 0);
        chk("t5_nrd", rd_addr_q.size(), 2);
        chk("t5_stay_idle", int'(a_busy), 0);
        clear_q();
        do_start('h0130, 2, 4, c0);
        wait_idle(1'b0, 200);
        check_scan("t5r", 'h0130, 2, 4, c0, 1'b1);

        // 5b: RD_LAT=3 timing and reset during WAIT of word 2 (cycles c0+7..c0+9)
        wait_idle(1'b1, 200);
        clear_q();
        do_start('h0040, 3, 1, c0);
        step(7);
        chk("t5b_rdcyc0", qget(b_rd_cyc_q, 0), c0 + 1);
        chk("t5b_rdcyc1", qget(b_rd_cyc_q, 1), c0 + 6);
        chk("t5b_btcyc0", qget(b_bt_cyc_q, 0), c0 + 5);
        chk("t5b_data0", qget(b_bt_data_q, 0), 'h40);
        #2;
        rst = 1'b0;
        #1;
        chk("t5b_async_busy", int'(b_busy), 0);
        chk("t5b_async_sel", int'(b_sel), 0);
        chk("t5b_async_dout", int'(b_dout), 0);
        chk("t5b_async_vld", int'(b_vld), 0);
        step(2);
        rst = 1'b1;
        step(2);
        chk("t5b_nodone", b_dn_q.size(), 0);
        chk("t5b_nbeat_abort", b_bt_data_q.size(), 1);
        clear_q();
        do_start('h00A0, 2, 2, c0);
        wait_idle(1'b1, 200);
        chk("t5b_r_rdcyc0", qget(b_rd_cyc_q, 0), c0 + 1);
        chk("t5b_r_rdcyc1", qget(b_rd_cyc_q, 1), c0 + 6);
        chk("t5b_r_btcyc0", qget(b_bt_cyc_q, 0), c0 + 5);
        chk("t5b_r_btcyc1", qget(b_bt_cyc_q, 1), c0 + 10);
        chk("t5b_r_data0", qget(b_bt_data_q, 0), 'hA0);
        chk("t5b_r_data1", qget(b_bt_data_q, 1), 'hA2);
        chk("t5b_r_ndone", b_dn_q.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
